// File: rtl/bus_sequencer.sv
// bus_sequencer: control sequencer for a basic 16-bit accumulator computer.
// Drives bus source selection, register strobes and the AC operation for
// each timing step of the fetch/decode/execute cycle.
module bus_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] ir_in,
    input  logic        dr_zero,
    output logic [2:0]  bus_code,
    output logic        ar_ld,
    output logic        ar_inr,
    output logic        pc_ld,
    output logic        pc_inr,
    output logic        dr_ld,
    output logic        dr_inr,
    output logic        ir_ld,
    output logic        ac_ld,
    output logic        mem_wr,
    output logic [2:0]  alu_op,
    output logic [2:0]  sc,
    output logic        halted
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] sc_next;
    logic       end_instr;
    logic       do_halt;
    logic [2:0] op_d;
    logic       op_i;

    assign op_d   = ir_in[14:12];
    assign op_i   = ir_in[15];
    assign halted = (state == IDLE);

    // State and timing-step registers; reset drops straight back to IDLE at T0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sc    <= 3'd0;
        end else begin
            state <= state_next;
            sc    <= sc_next;
        end
    end

    // Decode the current step into bus/strobe/ALU controls and the next state.
    always_comb begin
        bus_code   = 3'b000;
        ar_ld      = 1'b0;
        ar_inr     = 1'b0;
        pc_ld      = 1'b0;
        pc_inr     = 1'b0;
        dr_ld      = 1'b0;
        dr_inr     = 1'b0;
        ir_ld      = 1'b0;
        ac_ld      = 1'b0;
        mem_wr     = 1'b0;
        alu_op     = 3'b000;
        end_instr  = 1'b0;
        do_halt    = 1'b0;
        state_next = state;
        sc_next    = 3'd0;

        if (state == IDLE) begin
            if (start) begin
                state_next = RUN;
            end
        end else begin
            case (sc)
                3'd0: begin
                    bus_code = 3'b010;
                    ar_ld    = 1'b1;
                end
                3'd1: begin
                    bus_code = 3'b111;
                    ir_ld    = 1'b1;
                    pc_inr   = 1'b1;
                end
                3'd2: begin
                    bus_code = 3'b101;
                    ar_ld    = 1'b1;
                end
                3'd3: begin
                    if (op_d != 3'd7) begin
                        if (op_i) begin
                            bus_code = 3'b111;
                            ar_ld    = 1'b1;
                        end
                    end else begin
                        end_instr = 1'b1;
                        if (!op_i) begin
                            if (ir_in[11]) begin
                                alu_op = 3'b100;
                                ac_ld  = 1'b1;
                            end else if (ir_in[9]) begin
                                alu_op = 3'b101;
                                ac_ld  = 1'b1;
                            end else if (ir_in[5]) begin
                                alu_op = 3'b110;
                                ac_ld  = 1'b1;
                            end
                            do_halt = ir_in[0];
                        end
                    end
                end
                3'd4: begin
                    case (op_d)
                        3'd0, 3'd1, 3'd2, 3'd6: begin
                            bus_code = 3'b111;
                            dr_ld    = 1'b1;
                        end
                        3'd3: begin
                            bus_code  = 3'b100;
                            mem_wr    = 1'b1;
                            end_instr = 1'b1;
                        end
                        3'd4: begin
                            bus_code  = 3'b001;
                            pc_ld     = 1'b1;
                            end_instr = 1'b1;
                        end
                        3'd5: begin
                            bus_code = 3'b010;
                            mem_wr   = 1'b1;
                            ar_inr   = 1'b1;
                        end
                        default: end_instr = 1'b1;
                    endcase
                end
                3'd5: begin
                    case (op_d)
                        3'd0, 3'd1, 3'd2: begin
                            ac_ld     = 1'b1;
                            alu_op    = op_d + 3'd1;
                            end_instr = 1'b1;
                        end
                        3'd5: begin
                            bus_code  = 3'b001;
                            pc_ld     = 1'b1;
                            end_instr = 1'b1;
                        end
                        3'd6: dr_inr = 1'b1;
                        default: end_instr = 1'b1;
                    endcase
                end
                3'd6: begin
                    if (op_d == 3'd6) begin
                        bus_code = 3'b011;
                        mem_wr   = 1'b1;
                        pc_inr   = dr_zero;
                    end
                    end_instr = 1'b1;
                end
                default: end_instr = 1'b1;
            endcase

            if (do_halt) begin
                state_next = IDLE;
            end
            sc_next = end_instr ? 3'd0 : sc + 3'd1;
        end
    end

endmodule
